// File: rtl/mux_tree_sequencer_if.sv
// Handshake/bus bundle between the run controller and its environment.
// Carries the word stream, the tree datapath taps and the result handshake.
// The master side drives words, dp_v and out_ready; the slave side is the sequencer.
interface mux_tree_sequencer_if #(
    parameter int NBITS = 16
);
    logic             start;
    logic [3:0]       seed_in;
    logic [7:0]       word_in;
    logic             word_valid;
    logic             word_ready;
    logic [7:0]       dp_cur;
    logic [7:0]       dp_prev;
    logic [3:0]       dp_a;
    logic             dp_v;
    logic             busy;
    logic             out_valid;
    logic [NBITS-1:0] out_data;
    logic             out_ready;

    modport master (
        output start, seed_in, word_in, word_valid, dp_v, out_ready,
        input  word_ready, dp_cur, dp_prev, dp_a, busy, out_valid, out_data
    );

    modport slave (
        input  start, seed_in, word_in, word_valid, dp_v, out_ready,
        output word_ready, dp_cur, dp_prev, dp_a, busy, out_valid, out_data
    );
endinterface

// File: rtl/mux_tree_sequencer.sv
// Run controller for the 4-layer mux-tree generator: previous word, 4-bit history, result word.
// Latency: out_valid rises the cycle after the NBITS-th accepted word (min run NBITS+2 cycles).
// Backpressure: word_ready only in RUN; result is held in DONE until out_ready.
module mux_tree_sequencer #(
    parameter int NBITS = 16,
    parameter int CW    = 8
) (
    input  logic               clk,
    input  logic               rst,
    mux_tree_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       prev_q, prev_d;
    logic [3:0]       hist_q, hist_d;
    logic [CW-1:0]    count_q, count_d;
    logic [NBITS-1:0] out_data_q, out_data_d;

    logic             step;
    logic             v_bit;

    // An undriven or unknown tree output is taken as 0, like the original flop would capture.
    assign v_bit = (bus.dp_v === 1'b1);

    // Registered state, history, previous word, step counter and result word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            prev_q     <= '0;
            hist_q     <= '0;
            count_q    <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            hist_q     <= hist_d;
            count_q    <= count_d;
            out_data_q <= out_data_d;
        end
    end

    // Next-state and datapath updates; every register holds unless a start or a step touches it.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        hist_d     = hist_q;
        count_d    = count_q;
        out_data_d = out_data_q;
        step       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    hist_d     = bus.seed_in;
                    prev_d     = '0;
                    count_d    = '0;
                    out_data_d = '0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                step = bus.word_valid;
                if (step) begin
                    // A[1] is not a tree select but still carries history into A[2].
                    hist_d     = {hist_q[2:0], v_bit};
                    prev_d     = bus.word_in;
                    out_data_d = {out_data_q[NBITS-2:0], v_bit};
                    count_d    = count_q + CW'(1);
                    if (count_q == CW'(NBITS - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // A start alongside out_ready is dropped; IDLE samples start from the next cycle.
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status and datapath taps decoded straight from registered state.
    always_comb begin
        bus.word_ready = (state_q == S_RUN);
        bus.busy       = (state_q == S_RUN) || (state_q == S_DONE);
        bus.out_valid  = (state_q == S_DONE);
        bus.out_data   = out_data_q;
        bus.dp_cur     = bus.word_in;
        bus.dp_prev    = prev_q;
        bus.dp_a       = hist_q;
    end

endmodule

// File: tb/tb_mux_tree_sequencer.sv
module tb_mux_tree_sequencer;

    logic clk;
    logic rst;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mux_tree_sequencer_if #(.NBITS(4))  if4 ();
    mux_tree_sequencer_if #(.NBITS(16)) if16 ();

    mux_tree_sequencer #(.NBITS(4), .CW(8)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4.slave)
    );

    mux_tree_sequencer #(.NBITS(16), .CW(8)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden mux tree: word bits {an..hn} = bit7..bit0, history a = A[3:0].
    function automatic logic tree(input logic [7:0] cur, input logic [7:0] prv, input logic [3:0] a);
        logic an, bn, cn, dn, en, fn, gn, hn;
        logic o1, o2, o3, o4, o5, o6, o7, o8, t1, t2, t3, t4, u1, u2;
        {an, bn, cn, dn, en, fn, gn, hn} = cur;
        o1 = prv[7] ? an : en;
        o2 = prv[6] ? an : en;
        o3 = prv[5] ? bn : fn;
        o4 = prv[4] ? bn : fn;
        o5 = prv[3] ? cn : gn;
        o6 = prv[2] ? cn : gn;
        o7 = prv[1] ? dn : hn;
        o8 = prv[0] ? dn : hn;
        t1 = a[3] ? o1 : o2;
        t2 = a[3] ? o3 : o4;
        t3 = a[3] ? o5 : o6;
        t4 = a[3] ? o7 : o8;
        u1 = a[2] ? t1 : t2;
        u2 = a[2] ? t3 : t4;
        return a[0] ? u1 : u2;
    endfunction

    always_comb if4.dp_v  = tree(if4.dp_cur,  if4.dp_prev,  if4.dp_a);
    always_comb if16.dp_v = tree(if16.dp_cur, if16.dp_prev, if16.dp_a);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One NBITS=4 run with a constant word; model tracks history/prev step by step.
    task automatic run4(input logic [3:0] seed, input logic [7:0] w, input bit bubbles,
                        input logic [3:0] exp_data);
        logic [3:0] ma;
        logic [7:0] mp;
        logic       v;
        ma = seed;
        mp = 8'h00;
        if4.seed_in = seed;
        if4.start   = 1'b1;
        tick();
        if4.start = 1'b0;
        chk("run_busy", {31'd0, if4.busy}, 32'd1);
        chk("run_seed_a", {28'd0, if4.dp_a}, {28'd0, seed});
        for (int i = 0; i < 4; i++) begin
            if (bubbles && i > 0) begin
                if4.word_valid = 1'b0;
                tick();
                chk("gap_a", {28'd0, if4.dp_a}, {28'd0, ma});
                chk("gap_prev", {24'd0, if4.dp_prev}, {24'd0, mp});
            end
            if4.word_in    = w;
            if4.word_valid = 1'b1;
            v  = tree(w, mp, ma);
            ma = {ma[2:0], v};
            mp = w;
            tick();
            if4.word_valid = 1'b0;
            chk("step_a", {28'd0, if4.dp_a}, {28'd0, ma});
            chk("out_valid_timing", {31'd0, if4.out_valid}, (i == 3) ? 32'd1 : 32'd0);
        end
        chk("out_data", {28'd0, if4.out_data}, {28'd0, exp_data});
        chk("final_prev", {24'd0, if4.dp_prev}, {24'd0, w});
    endtask

    task automatic release4();
        if4.out_ready = 1'b1;
        tick();
        if4.out_ready = 1'b0;
        chk("release_busy", {31'd0, if4.busy}, 32'd0);
        chk("release_valid", {31'd0, if4.out_valid}, 32'd0);
    endtask

    initial begin
        logic [3:0]  ma;
        logic [7:0]  mp;
        logic [15:0] mres;
        logic [7:0]  words [16];
        logic        v;

        rst = 1'b1;
        if4.start = 0;  if4.seed_in = 0;  if4.word_in = 0;  if4.word_valid = 0;  if4.out_ready = 0;
        if16.start = 0; if16.seed_in = 0; if16.word_in = 0; if16.word_valid = 0; if16.out_ready = 0;
        tick();
        tick();
        chk("rst_busy", {31'd0, if4.busy}, 32'd0);
        chk("rst_word_ready", {31'd0, if4.word_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, if4.out_valid}, 32'd0);
        chk("rst_dp_a", {28'd0, if4.dp_a}, 32'd0);
        chk("rst_dp_prev", {24'd0, if4.dp_prev}, 32'd0);
        chk("rst_out_data", {28'd0, if4.out_data}, 32'd0);
        rst = 1'b0;
        tick();

        // IDLE ignores words
        if4.word_valid = 1'b1;
        if4.word_in    = 8'hA5;
        tick();
        chk("idle_ignores_word", {24'd0, if4.dp_prev}, 32'd0);
        if4.word_valid = 1'b0;

        // T1: reset pulse mid-run after two steps, checked within the same cycle
        if4.seed_in = 4'h5;
        if4.start   = 1'b1;
        tick();
        if4.start      = 1'b0;
        if4.word_valid = 1'b1;
        if4.word_in    = 8'h3C;
        tick();
        if4.word_in    = 8'hC3;
        tick();
        if4.word_valid = 1'b0;
        chk("t1_mid_busy", {31'd0, if4.busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t1_busy", {31'd0, if4.busy}, 32'd0);
        chk("t1_word_ready", {31'd0, if4.word_ready}, 32'd0);
        chk("t1_dp_a", {28'd0, if4.dp_a}, 32'd0);
        chk("t1_dp_prev", {24'd0, if4.dp_prev}, 32'd0);
        chk("t1_out_valid", {31'd0, if4.out_valid}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("t1_stays_idle", {31'd0, if4.busy}, 32'd0);

        // T2 / T3 / T4
        run4(4'hF, 8'h08, 1'b0, 4'hF);
        chk("t2_final_a", {28'd0, if4.dp_a}, 32'hF);
        release4();
        chk("t2_hold_a_idle", {28'd0, if4.dp_a}, 32'hF);
        run4(4'h0, 8'h08, 1'b0, 4'h0);
        chk("t3_final_a", {28'd0, if4.dp_a}, 32'h0);
        release4();
        run4(4'h0, 8'hFF, 1'b0, 4'hF);
        release4();
        run4(4'hF, 8'h08, 1'b1, 4'hF);

        // T5: backpressure in DONE, start ignored while held
        if4.start   = 1'b1;
        if4.seed_in = 4'h3;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_hold_valid", {31'd0, if4.out_valid}, 32'd1);
            chk("t5_hold_data", {28'd0, if4.out_data}, 32'hF);
        end
        if4.out_ready = 1'b1;
        tick();
        if4.out_ready = 1'b0;
        chk("t5_start_with_ready_dropped", {31'd0, if4.busy}, 32'd0);
        chk("t5_valid_low", {31'd0, if4.out_valid}, 32'd0);
        tick();
        if4.start = 1'b0;
        chk("t5_start_next_cycle", {31'd0, if4.word_ready}, 32'd1);
        chk("t5_seed_loaded", {28'd0, if4.dp_a}, 32'h3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // T6: NBITS=16 random runs against the step-by-step model
        for (int r = 0; r < 200; r++) begin
            ma = 4'($urandom);
            mp = 8'h00;
            mres = 16'h0;
            for (int k = 0; k < 16; k++) begin
                words[k] = 8'($urandom);
                v    = tree(words[k], mp, ma);
                ma   = {ma[2:0], v};
                mp   = words[k];
                mres = {mres[14:0], v};
            end
            if16.seed_in = 4'(ma >> 0);
            if16.seed_in = 4'h0;
            ma = 4'h0;
            // recompute with the seed actually driven so the model owns it
            ma = 4'($urandom);
            if16.seed_in = ma;
            mp = 8'h00;
            mres = 16'h0;
            for (int k = 0; k < 16; k++) begin
                v    = tree(words[k], mp, ma);
                ma   = {ma[2:0], v};
                mp   = words[k];
                mres = {mres[14:0], v};
            end
            if16.start = 1'b1;
            tick();
            if16.start = 1'b0;
            for (int k = 0; k < 16; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    if16.word_valid = 1'b0;
                    tick();
                end
                if16.word_in    = words[k];
                if16.word_valid = 1'b1;
                tick();
            end
            if16.word_valid = 1'b0;
            chk("t6_out_valid", {31'd0, if16.out_valid}, 32'd1);
            chk("t6_out_data", {16'd0, if16.out_data}, {16'd0, mres});
            if16.out_ready = 1'b1;
            tick();
            if16.out_ready = 1'b0;
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
